fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the MUSA pipelined core, directly upstream of the decode stage.
- Holds the program counter and drives the instruction-memory address.
- Selects the next PC from the decode stage's pcSrc, PCWrite, jump_jpc, push and pop outputs.
- Keeps a hardware return-address stack (RAS) for push/pop and drives the IF/ID pipeline register that feeds decode's instruction input.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- STACK_DEPTH, 8, RAS entries (power of two, 2..64).
- NOP_WORD, 32'h00000000, word inserted into IF/ID on flush.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- pcSrc  input  3  next-PC select from decode
- PCWrite  input  1  1 = advance PC and IF/ID; 0 = stall
- flush  input  1  load NOP_WORD into IF/ID
- push  input  1  push return address onto RAS
- pop  input  1  pop RAS (used with pcSrc=3'b100)
- jump_jpc  input  32  word-shifted jump field from decode
- branch_target  input  32  computed branch address (ALU result)
- reg_target  input  32  register jump address (readData1)
- imem_rdata  input  32  instruction word at imem_addr (asynchronous read)
- imem_addr  output  32  instruction-memory address, equals pc
- pc  output  32  current PC
- instruction  output  32  IF/ID instruction register
- pc_plus4  output  32  IF/ID copy of fetched PC+4
- stack_empty  output  1  RAS holds 0 entries
- stack_full  output  1  RAS holds STACK_DEPTH entries
- stack_overflow  output  1  sticky, push while full
- stack_underflow  output  1  sticky, pop while empty

Behaviour:
Reset:
- rst is sampled on the clk rising edge.
- pc=RESET_PC; instruction=NOP_WORD; pc_plus4=0; RAS count=0; stack_empty=1; stack_full=0; overflow and underflow flags=0.

Next-PC selection (combinational; seq = pc+4, modulo 2^32 wrap):
- 000: seq.
- 001: branch_target.
- 010: {pc_plus4[31:28], jump_jpc[27:0]}.
- 011: reg_target.
- 100: RAS top. If the RAS is empty, use seq.
- 101/110/111: seq.

Clocked update when PCWrite=1:
- pc <= next_pc.
- pc_plus4 <= pc+4.
- instruction <= flush ? NOP_WORD : imem_rdata.
- Fetch latency: 1 cycle from pc to instruction.

When PCWrite=0:
- pc, pc_plus4 and instruction hold.
- Exception: if flush=1, instruction <= NOP_WORD (flush beats stall).

RAS (circular array plus count/pointer):
- Push and pop act only when PCWrite=1.
- Push stores pc_plus4 (return address of the call in ID).
- Push while full: no write, stack_overflow<=1.
- Pop while empty: no change, stack_underflow<=1.
- Push and pop in the same cycle: top entry is replaced with pc_plus4, count unchanged. If empty, this acts as a plain push.
- Sticky flags clear only on rst.
- rst mid-operation discards all RAS contents.

Optional Feature:
- Macro: FETCH_RAS_CIRCULAR_EN.
- Defined: a push while full overwrites the oldest entry, count stays STACK_DEPTH, and stack_overflow is still set.
- Undefined: a push while full is dropped, as described above.

Test Plan:
1. Reset release with imem returning addr^32'hA5A5A5A5, pcSrc=000, PCWrite=1 -> pc runs 0,4,8,... and instruction lags pc by one cycle with the matching data.
2. pc=0x1000, pcSrc=001, branch_target=0x2000 -> next cycle pc=0x2000; pc_plus4=0x1004.
3. pc_plus4=0x3000_0010, pcSrc=010, jump_jpc=0x0400_0040 -> pc=0x3400_0040.
4. push with pc_plus4=0x108, then later pop with pcSrc=100 -> pc=0x108 and stack_empty=1 afterward. A second pop -> pc=pc+4 and stack_underflow=1.
5. 9 pushes with STACK_DEPTH=8 -> stack_full=1 and stack_overflow=1.
   - Feature off: 8 pops return entries 8..1.
   - Feature on: pops return entries 9..2.
6. PCWrite=0 for 3 cycles with flush=1 on the 2nd cycle -> pc frozen, instruction=NOP_WORD from that cycle. After PCWrite returns to 1 with pcSrc=000, fetch resumes at the held pc.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MUSA pipelined core.
//
// Holds the program counter, drives the instruction-memory address, selects
// the next PC from decode's controls and keeps a hardware return-address
// stack (RAS). Drives the IF/ID register (instruction, pc_plus4) feeding decode.
//
// Optional build macro:
//   FETCH_RAS_CIRCULAR_EN - when defined, a push onto a full RAS overwrites
//                           the oldest entry instead of being dropped
//                           (stack_overflow is set either way).
//
// Ports:
//   clk, rst         - core clock; synchronous active-high reset
//   pcSrc            - next-PC select (000 seq, 001 branch, 010 jump,
//                      011 register, 100 RAS top, others seq)
//   PCWrite          - 1 advances PC and IF/ID, 0 stalls
//   flush            - load NOP_WORD into IF/ID (also during a stall)
//   push, pop        - RAS controls, effective only when PCWrite=1
//   jump_jpc         - word-shifted jump field
//   branch_target    - computed branch address
//   reg_target       - register jump address
//   imem_rdata       - instruction at imem_addr (asynchronous read)
//   imem_addr, pc    - current program counter
//   instruction      - IF/ID instruction register
//   pc_plus4         - IF/ID copy of fetched PC+4
//   stack_empty/full - RAS occupancy status
//   stack_overflow   - sticky: push while full
//   stack_underflow  - sticky: pop while empty
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pcSrc,
    input  logic        PCWrite,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] jump_jpc,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        stack_empty,
    output logic        stack_full,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [31:0]      ras_mem [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr;      // next free slot; top entry is wr_ptr-1
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_cnt;

    logic [31:0]      seq_pc;
    logic [31:0]      next_pc;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic             ptr_inc, ptr_dec;
    logic             cnt_inc, cnt_dec;
    logic             set_ovf, set_unf;

    assign top_ptr     = wr_ptr - 1'b1;
    assign stack_empty = (ras_cnt == '0);
    assign stack_full  = (ras_cnt == FULL_CNT);
    assign imem_addr   = pc;
    assign seq_pc      = pc + 32'd4;

    always_comb begin
        next_pc = seq_pc;
        case (pcSrc)
            3'b001:  next_pc = branch_target;
            3'b010:  next_pc = {pc_plus4[31:28], jump_jpc[27:0]};
            3'b011:  next_pc = reg_target;
            3'b100:  next_pc = stack_empty ? seq_pc : ras_mem[top_ptr];
            default: next_pc = seq_pc;
        endcase
    end

    // Push and pop together on a non-empty stack replace the top in place;
    // on an empty stack that combination degenerates to a plain push.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        ptr_inc   = 1'b0;
        ptr_dec   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (PCWrite && !rst) begin
            if (push && pop && !stack_empty) begin
                mem_we    = 1'b1;
                mem_waddr = top_ptr;
            end else if (push) begin
                if (!stack_full) begin
                    mem_we  = 1'b1;
                    ptr_inc = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    set_ovf = 1'b1;
`ifdef FETCH_RAS_CIRCULAR_EN
                    // When full, wr_ptr points at the oldest entry.
                    mem_we  = 1'b1;
                    ptr_inc = 1'b1;
`endif
                end
            end else if (pop) begin
                if (stack_empty) begin
                    set_unf = 1'b1;
                end else begin
                    ptr_dec = 1'b1;
                    cnt_dec = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ras_mem[mem_waddr] <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            ras_cnt         <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (ptr_inc) wr_ptr <= wr_ptr + 1'b1;
            else if (ptr_dec) wr_ptr <= wr_ptr - 1'b1;
            if (cnt_inc) ras_cnt <= ras_cnt + 1'b1;
            else if (cnt_dec) ras_cnt <= ras_cnt - 1'b1;
            if (set_ovf) stack_overflow  <= 1'b1;
            if (set_unf) stack_underflow <= 1'b1;
        end
    end

    // Flush wins over a stall: the IF/ID instruction is cleared even when
    // the PC and pc_plus4 are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pc_plus4    <= '0;
            instruction <= NOP_WORD;
        end else if (PCWrite) begin
            pc          <= next_pc;
            pc_plus4    <= seq_pc;
            instruction <= flush ? NOP_WORD : imem_rdata;
        end else if (flush) begin
            instruction <= NOP_WORD;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] IMASK    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pcSrc;
    logic        PCWrite, flush, push, pop;
    logic [31:0] jump_jpc, branch_target, reg_target;
    logic [31:0] imem_rdata, imem_addr, pc, instruction, pc_plus4;
    logic        stack_empty, stack_full, stack_overflow, stack_underflow;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        empty, full, ovf, unf;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] m_stack [$];
    logic [31:0] m_pc, m_ins, m_pp4;
    logic        m_ovf, m_unf;

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .STACK_DEPTH(DEPTH),
        .NOP_WORD   (NOP_WORD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pcSrc          (pcSrc),
        .PCWrite        (PCWrite),
        .flush          (flush),
        .push           (push),
        .pop            (pop),
        .jump_jpc       (jump_jpc),
        .branch_target  (branch_target),
        .reg_target     (reg_target),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .instruction    (instruction),
        .pc_plus4       (pc_plus4),
        .stack_empty    (stack_empty),
        .stack_full     (stack_full),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ IMASK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict the post-edge state, compare after the edge.
    task automatic step(input logic r, input logic [2:0] src, input logic pcw,
                        input logic fl, input logic pu, input logic po,
                        input logic [31:0] bt, input logic [31:0] rt,
                        input logic [31:0] jpc);
        logic [31:0] seq, npc;
        exp_t e, o;
        rst = r; pcSrc = src; PCWrite = pcw; flush = fl; push = pu; pop = po;
        branch_target = bt; reg_target = rt; jump_jpc = jpc;
        if (r) begin
            m_pc = RESET_PC; m_ins = NOP_WORD; m_pp4 = '0;
            m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            seq = m_pc + 32'd4;
            case (src)
                3'b001:  npc = bt;
                3'b010:  npc = {m_pp4[31:28], jpc[27:0]};
                3'b011:  npc = rt;
                3'b100:  npc = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : seq;
                default: npc = seq;
            endcase
            if (pcw) begin
                if (pu && po && m_stack.size() > 0) begin
                    m_stack[m_stack.size()-1] = m_pp4;
                end else if (pu) begin
                    if (m_stack.size() < DEPTH) begin
                        m_stack.push_back(m_pp4);
                    end else begin
                        m_ovf = 1'b1;
`ifdef FETCH_RAS_CIRCULAR_EN
                        void'(m_stack.pop_front());
                        m_stack.push_back(m_pp4);
`endif
                    end
                end else if (po) begin
                    if (m_stack.size() == 0) m_unf = 1'b1;
                    else void'(m_stack.pop_back());
                end
                m_ins = fl ? NOP_WORD : (m_pc ^ IMASK);
                m_pp4 = seq;
                m_pc  = npc;
            end else if (fl) begin
                m_ins = NOP_WORD;
            end
        end
        e.pc = m_pc; e.ins = m_ins; e.pp4 = m_pp4;
        e.empty = (m_stack.size() == 0); e.full = (m_stack.size() == DEPTH);
        e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("pc", pc, o.pc);
        check("imem_addr", imem_addr, o.pc);
        check("instruction", instruction, o.ins);
        check("pc_plus4", pc_plus4, o.pp4);
        check("stack_empty", 32'(stack_empty), 32'(o.empty));
        check("stack_full", 32'(stack_full), 32'(o.full));
        check("stack_overflow", 32'(stack_overflow), 32'(o.ovf));
        check("stack_underflow", 32'(stack_underflow), 32'(o.unf));
    endtask

    task automatic seqs(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 3'b000, 1, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic br(input logic [31:0] t);
        step(0, 3'b001, 1, 0, 0, 0, t, '0, '0);
    endtask

    initial begin
        rst = 1'b1; pcSrc = '0; PCWrite = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
        branch_target = '0; reg_target = '0; jump_jpc = '0;
        @(posedge clk); #1;

        // reset state
        step(1, 3'b000, 1, 0, 0, 0, '0, '0, '0);
        step(1, 3'b000, 1, 0, 0, 0, '0, '0, '0);
        check("rst_pc", pc, RESET_PC);
        check("rst_ins", instruction, NOP_WORD);

        // sequential fetch, instruction lags pc by one cycle
        seqs(5);
        check("seq_pc", pc, 32'h14);
        check("seq_ins", instruction, 32'h10 ^ IMASK);

        // branch
        br(32'h1000);
        br(32'h2000);
        check("br_pc", pc, 32'h2000);
        check("br_pp4", pc_plus4, 32'h1004);

        // jump keeps pc_plus4 upper nibble
        br(32'h3000_000C);
        seqs(1);
        step(0, 3'b010, 1, 0, 0, 0, '0, '0, 32'h0400_0040);
        check("jmp_pc", pc, 32'h3400_0040);

        // register jump and pc wrap
        step(0, 3'b011, 1, 0, 0, 0, '0, 32'hFFFF_FFFC, '0);
        seqs(2);
        check("wrap_pc", pc, 32'h4);

        // push return address 0x108, later pop
        br(32'h104);
        seqs(1);
        step(0, 3'b000, 1, 0, 1, 0, '0, '0, '0);
        seqs(3);
        step(0, 3'b100, 1, 0, 0, 1, '0, '0, '0);
        check("ret_pc", pc, 32'h108);
        step(0, 3'b100, 1, 0, 0, 1, '0, '0, '0);
        check("uflow_pc", pc, 32'h10C);
        check("uflow", 32'(stack_underflow), 32'd1);

        // overfill and drain
        for (int unsigned i = 0; i < DEPTH + 1; i++) step(0, 3'b000, 1, 0, 1, 0, '0, '0, '0);
        for (int unsigned i = 0; i < DEPTH; i++) step(0, 3'b100, 1, 0, 0, 1, '0, '0, '0);

        // push+pop replace, push+pop on empty
        step(0, 3'b000, 1, 0, 1, 1, '0, '0, '0);
        step(0, 3'b000, 1, 0, 1, 0, '0, '0, '0);
        step(0, 3'b000, 1, 0, 1, 1, '0, '0, '0);
        step(0, 3'b100, 1, 0, 0, 1, '0, '0, '0);

        // stall with flush on the second cycle, push/pop ignored while stalled
        seqs(2);
        step(0, 3'b001, 0, 0, 1, 0, 32'h9000, '0, '0);
        step(0, 3'b000, 0, 1, 0, 1, '0, '0, '0);
        step(0, 3'b000, 0, 0, 0, 0, '0, '0, '0);
        check("stall_ins", instruction, NOP_WORD);
        seqs(2);
        // flush while advancing
        step(0, 3'b000, 1, 1, 0, 0, '0, '0, '0);

        // reset mid-operation
        step(0, 3'b000, 1, 0, 1, 0, '0, '0, '0);
        step(1, 3'b000, 1, 0, 0, 0, '0, '0, '0);
        step(0, 3'b100, 1, 0, 0, 1, '0, '0, '0);

        // random traffic
        for (int unsigned i = 0; i < 200; i++) begin
            step(0, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), $urandom & 32'hFFFF_FFFC,
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'h0FFF_FFFC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
